// File: rtl/gpio_debounce_pkg.sv
// Shared defaults and types for the GPIO input debounce stage.
// Holds the default pin count and widths, the gpio_in reset level and the per-pin action type.
package gpio_debounce_pkg;

    localparam int unsigned DefN  = 32;
    localparam int unsigned DefCw = 8;
    localparam int unsigned DefPw = 16;

    // Level gpio_in reports while reset is asserted
    localparam logic GpioInRst = 1'b0;

    typedef enum logic [2:0] {
        ActFollow,
        ActClear,
        ActFlip,
        ActCount,
        ActHold
    } cnt_act_e;

endpackage

// File: rtl/gpio_debounce_cell.sv
// One pin of the debounce stage: two-flop synchronizer, stability counter,
// stable level register and a registered change strobe.
module gpio_debounce_cell
    import gpio_debounce_pkg::*;
#(
    parameter int unsigned CW = DefCw
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          en,
    input  logic [CW-1:0] limit,
    input  logic          pad,
    output logic          level,
    output logic          change
);

    logic          s1, sync, stable, stable_next, change_q;
    logic [CW-1:0] cnt, cnt_next;
    logic [CW:0]   lim_eff, cnt_inc;
    cnt_act_e      act;

    always_comb begin
        // A limit of zero behaves like one; the compare is one bit wider so cnt+1 never wraps
        lim_eff     = (limit == '0) ? {{CW{1'b0}}, 1'b1} : {1'b0, limit};
        cnt_inc     = {1'b0, cnt} + {{CW{1'b0}}, 1'b1};
        stable_next = stable;
        cnt_next    = cnt;

        if (!en)                              act = ActFollow;
        else if (sync == stable)              act = ActClear;
        else if (tick && cnt_inc >= lim_eff)  act = ActFlip;
        else if (tick)                        act = ActCount;
        else                                  act = ActHold;

        unique case (act)
            ActFollow: begin
                stable_next = sync;
                cnt_next    = '0;
            end
            ActClear:  cnt_next = '0;
            ActFlip: begin
                stable_next = sync;
                cnt_next    = '0;
            end
            ActCount:  cnt_next = cnt_inc[CW-1:0];
            ActHold:   cnt_next = cnt;
            default:   cnt_next = cnt;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1       <= 1'b0;
            sync     <= 1'b0;
            stable   <= GpioInRst;
            cnt      <= '0;
            change_q <= 1'b0;
        end else begin
            s1       <= pad;
            sync     <= s1;
            stable   <= stable_next;
            cnt      <= cnt_next;
            change_q <= (stable_next != stable);
        end
    end

    assign level  = stable;
    assign change = change_q;

endmodule

// File: rtl/gpio_debounce.sv
// GPIO input conditioning: shared tick prescaler plus N independent debounce cells
// driving the GPIO block's gpio_in bus and a per-pin change strobe.
module gpio_debounce
    import gpio_debounce_pkg::*;
#(
    parameter int unsigned N  = DefN,
    parameter int unsigned CW = DefCw,
    parameter int unsigned PW = DefPw
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  cfg_en,
    input  logic [PW-1:0] cfg_div,
    input  logic [CW-1:0] cfg_limit,
    input  logic [N-1:0]  pad_in,
    output logic [N-1:0]  gpio_in,
    output logic [N-1:0]  change
);

    logic [PW-1:0] pre;
    logic          tick;

    assign tick = (pre == '0);

    // cfg_div is only sampled on reload, so a new divider lands at the next tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre <= '0;
        end else if (tick) begin
            pre <= cfg_div;
        end else begin
            pre <= pre - {{(PW-1){1'b0}}, 1'b1};
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_pin
        gpio_debounce_cell #(
            .CW(CW)
        ) u_cell (
            .clk    (clk),
            .reset  (reset),
            .tick   (tick),
            .en     (cfg_en[i]),
            .limit  (cfg_limit),
            .pad    (pad_in[i]),
            .level  (gpio_in[i]),
            .change (change[i])
        );
    end

endmodule

// File: tb/tb_gpio_debounce.sv
// Scoreboard bench for gpio_debounce (N=4): expected per-cycle gpio_in/change values are
// queued as each stimulus is applied and compared one cycle at a time, 1 time unit after each edge.
module tb_gpio_debounce;

    logic        clk;
    logic        reset;
    logic [3:0]  cfg_en;
    logic [15:0] cfg_div;
    logic [7:0]  cfg_limit;
    logic [3:0]  pad_in;
    logic [3:0]  gpio_in;
    logic [3:0]  change;

    gpio_debounce #(
        .N  (4),
        .CW (8),
        .PW (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_en    (cfg_en),
        .cfg_div   (cfg_div),
        .cfg_limit (cfg_limit),
        .pad_in    (pad_in),
        .gpio_in   (gpio_in),
        .change    (change)
    );

    typedef struct {
        string      tag;
        logic [3:0] g;
        logic [3:0] c;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [3:0] g, input logic [3:0] c, input int n);
        exp_t e;
        e.tag = tag;
        e.g   = g;
        e.c   = c;
        repeat (n) sb.push_back(e);
    endtask

    task automatic run(input int n);
        exp_t e;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check({e.tag, "_gpio"}, 32'(gpio_in), 32'(e.g));
                check({e.tag, "_chg"}, 32'(change), 32'(e.c));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clk       = 1'b0;
        reset     = 1'b1;
        pad_in    = 4'hF;
        cfg_en    = 4'h0;
        cfg_div   = 16'd0;
        cfg_limit = 8'd4;

        // Reset and bypass: pads high during reset, all outputs stay low
        push("rst", 4'h0, 4'h0, 2);
        run(2);
        reset = 1'b0;
        push("byp", 4'h0, 4'h0, 2);
        push("byp", 4'hF, 4'hF, 1);
        push("byp", 4'hF, 4'h0, 1);
        run(4);
        pad_in = 4'h0;
        push("byp_lo", 4'hF, 4'h0, 2);
        push("byp_lo", 4'h0, 4'hF, 1);
        push("byp_lo", 4'h0, 4'h0, 1);
        run(4);

        // Filter delay, div=0 limit=4: flip after the 6th edge
        cfg_en = 4'hF;
        pad_in = 4'h1;
        push("flt", 4'h0, 4'h0, 5);
        push("flt", 4'h1, 4'h1, 1);
        push("flt", 4'h1, 4'h0, 1);
        run(7);

        // Glitch of 3 cycles on pin 1 is rejected
        push("glitch", 4'h1, 4'h0, 10);
        pad_in = 4'h3;
        run(3);
        pad_in = 4'h1;
        run(7);

        // Dip inside a pulse restarts the count
        push("dip", 4'h1, 4'h0, 9);
        push("dip", 4'h3, 4'h2, 1);
        push("dip", 4'h3, 4'h0, 1);
        pad_in = 4'h3;
        run(3);
        pad_in = 4'h1;
        run(1);
        pad_in = 4'h3;
        run(7);

        // Asynchronous reset clears outputs without waiting for a clock edge
        reset = 1'b1;
        #1;
        check("rst_async_gpio", 32'(gpio_in), 32'h0);
        push("rst2", 4'h0, 4'h0, 2);
        run(2);

        // Prescaler div=3 limit=2: ticks at edges 5 and 9 after release
        cfg_div   = 16'd3;
        cfg_limit = 8'd2;
        reset     = 1'b0;
        pad_in    = 4'h4;
        push("pre", 4'h0, 4'h0, 8);
        push("pre", 4'h4, 4'h4, 1);
        push("pre", 4'h4, 4'h0, 1);
        run(10);

        // Limit of zero acts as one; let the new divider take effect first
        cfg_div   = 16'd0;
        cfg_limit = 8'd0;
        push("div_settle", 4'h4, 4'h0, 4);
        run(4);
        pad_in = 4'h5;
        push("lim0", 4'h4, 4'h0, 2);
        push("lim0", 4'h5, 4'h1, 1);
        push("lim0", 4'h5, 4'h0, 1);
        run(4);

        // Dropping cfg_en[3] mid-count makes the pin follow sync on the next edge
        cfg_limit = 8'd8;
        pad_in    = 4'hD;
        push("en_drop", 4'h5, 4'h0, 4);
        push("en_drop", 4'hD, 4'h8, 1);
        push("en_drop", 4'hD, 4'h0, 1);
        run(4);
        cfg_en = 4'h7;
        run(2);
        cfg_en = 4'hF;

        // Clear all pins via bypass before the reset-mid-count scenario
        cfg_en = 4'h0;
        pad_in = 4'h0;
        push("clr", 4'hD, 4'h0, 2);
        push("clr", 4'h0, 4'hD, 1);
        push("clr", 4'h0, 4'h0, 1);
        run(4);

        // Reset 4 cycles into an 8-tick count; after release the full latency applies
        cfg_en = 4'hF;
        pad_in = 4'h1;
        push("rmid", 4'h0, 4'h0, 4);
        run(4);
        reset = 1'b1;
        push("rmid_rst", 4'h0, 4'h0, 2);
        run(2);
        reset = 1'b0;
        push("rmid_rel", 4'h0, 4'h0, 9);
        push("rmid_rel", 4'h1, 4'h1, 1);
        push("rmid_rel", 4'h1, 4'h0, 1);
        run(11);

        check("sb_left", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_debounce.md
# gpio_debounce

Per-pin input conditioning stage that sits directly upstream of the GPIO block. It synchronizes raw pad inputs and suppresses bounce with a per-pin stable-time filter, then drives the GPIO block's `gpio_in` bus with clean, glitch-free levels. A one-cycle change strobe per pin is also produced, for optional wake/event logic.

## Interface
- `N`, 32, number of pins
- `CW`, 8, stability counter width (limit range 0..2^CW-1)
- `PW`, 16, prescaler width
- `clk`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high; one clock domain only
- `cfg_en`  in  N  per-pin filter enable; 0 = bypass (synchronize only)
- `cfg_div`  in  PW  prescaler reload; one tick every `cfg_div`+1 cycles
- `cfg_limit`  in  CW  consecutive mismatched ticks required to flip; 0 treated as 1
- `pad_in`  in  N  raw asynchronous pad inputs
- `gpio_in`  out  N  filtered level, registered; connects to GPIO block `gpio_in`
- `change`  out  N  one-cycle pulse, aligned with each `gpio_in` transition

## Operation
- **Reset values.** While `reset` is high, all state clears: sync flops, stable registers, counters, and prescaler go to 0. Outputs `gpio_in`=0 and `change`=0.
- **Synchronizer.** Two flops per pin, `pad_in` -> `s1` -> `sync`, built locally with active-high reset.
- **Prescaler.**
  - Down-counter `pre`. `tick` is asserted combinationally when `pre`==0; `pre` then reloads with `cfg_div`, otherwise it decrements.
  - `cfg_div`=0 gives a tick every cycle.
  - A change to `cfg_div` takes effect at the next reload.
- **Filter pin** (`cfg_en[i]`=1), evaluated in priority order:
  - If `sync[i]`==`stable[i]`: `cnt[i]` <= 0. Any single-cycle return to the stable value, even between ticks, clears the count.
  - Else if `tick` and `cnt[i]`+1 >= max(`cfg_limit`,1), compared at CW+1 bits: `stable[i]` <= `sync[i]`, `cnt[i]` <= 0.
  - Else if `tick`: `cnt[i]` <= `cnt[i]`+1.
  - Else: `cnt[i]` is held.
  - Lowering `cfg_limit` below the current `cnt[i]` flips the pin at the next mismatched tick. No counter overflow is possible.
- **Bypass pin** (`cfg_en[i]`=0): `stable[i]` <= `sync[i]` every cycle, and `cnt[i]` <= 0.
- **En toggle mid-count.**
  - 1->0: the pin follows `sync` on the next edge.
  - 0->1: the count starts from 0.
- **Outputs.** `gpio_in` = `stable`. `change[i]` is registered as (`stable_next[i]` != `stable[i]`), so it is high exactly in the cycle `gpio_in[i]` first shows the new value.
- **Pin independence.** Pins are independent; simultaneous flips on several pins produce simultaneous `change` bits.

## Timing
- **Bypass latency.** A pad edge sampled at edge k appears on `gpio_in` after edge k+2.
- **Filter latency, `cfg_div`=0.** 2 + max(`cfg_limit`,1) edges from the sampling edge.
- **Filter latency, general.** The pin flips on the max(L,1)-th mismatched tick after `sync` changes. Latency is between 2+(L-1)(D+1)+1 and 2+L(D+1) edges, where L=`cfg_limit` and D=`cfg_div`.
- **Reset mid-operation.** Reset clears everything at once. After release, a pad held high follows the normal latency from 0.
- **Config inputs.** Config inputs are static-sampled every cycle and need no handshake.

## Structure
- **Shared defines header** (beside the GPIO register map): default `N`/`CW`/`PW`, and the reset value of `gpio_in` (0).
- **Sub-module `gpio_debounce_cell`.** One pin's logic: sync pair, `cnt`, `stable`, `change` flop. Its inputs are `tick`, `cfg_en` bit, and `cfg_limit`. It is instantiated N times by a generate loop.
- **Top level.** The prescaler is instantiated once, at the top level.

## Test plan
All scenarios use N=4, CW=8, PW=16.
1. **Reset and bypass.** Stimulus: `pad_in`=4'hF during reset, with `cfg_en`=0. Required: `gpio_in`=0 and `change`=0 while in reset. After release, `gpio_in`=4'hF after the 3rd edge, and `change`=4'hF for exactly one cycle.
2. **Filter delay.** Stimulus: `cfg_en`=4'hF, `cfg_div`=0, `cfg_limit`=4, `pad_in[0]` 0->1 held. Required: `gpio_in[0]` rises after exactly the 6th edge, and `change[0]` pulses once.
3. **Glitch rejection.** Stimulus: same config; `pad_in[1]` high for 3 cycles, then low. Required: `gpio_in[1]` stays 0 and `change[1]` never asserts. Repeat with a 1-cycle dip inside a 6-cycle pulse: the count restarts and the pin flips only after 4 further stable cycles.
4. **Prescaler.** Stimulus: `cfg_div`=3, `cfg_limit`=2, `pad_in[2]` 0->1 held. Required: `gpio_in[2]` flips between 7 and 10 edges after the pad change, exactly on the 2nd tick with mismatch.
5. **Config edges.** Stimulus: `cfg_limit`=0. Required: the pin flips at the first mismatched tick (behaves as 1). Stimulus: `cfg_en[3]` dropped from 1 to 0 mid-count. Required: `gpio_in[3]` equals `sync[3]` on the next edge.
6. **Reset mid-count.** Stimulus: `cfg_limit`=8, `cfg_div`=0; assert `reset` 4 cycles after `pad_in[0]` rises, hold 2 cycles, release. Required: `gpio_in`=0 immediately, with no `change` pulse. After release, `gpio_in[0]` rises after the 10th edge (2 sync + 8 ticks).
